// File: rtl/cbus_clint_if.sv
// CBus request/response bundle between an initiator (master) and a target (slave).
// Request and response data are split into req_data and resp_data.
interface cbus_clint_if;
   logic        valid;
   logic        is_write;
   logic [2:0]  size;
   logic [63:0] addr;
   logic [7:0]  strobe;
   logic [63:0] req_data;
   logic [7:0]  len;
   logic [1:0]  burst;
   logic        ready;
   logic        last;
   logic [63:0] resp_data;

   modport master (
      output valid, is_write, size, addr, strobe, req_data, len, burst,
      input  ready, last, resp_data
   );

   modport slave (
      input  valid, is_write, size, addr, strobe, req_data, len, burst,
      output ready, last, resp_data
   );
endinterface

// File: rtl/cbus_clint.sv
// Core-local interruptor on CBus: msip, mtimecmp and a free-running mtime,
// with timer and software interrupt lines derived from them.
module cbus_clint #(
   parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   cbus_clint_if.slave  bus,
   output logic         trint,
   output logic         swint
);
   localparam int unsigned DIV        = (TICK_DIV < 1) ? 1 : TICK_DIV;
   localparam logic [31:0] DIV_M1     = 32'(DIV - 1);
   localparam logic [12:0] MSIP_IDX   = 13'h0000;
   localparam logic [12:0] CMP_IDX    = 13'h0800;
   localparam logic [12:0] MTIME_IDX  = 13'h17FF;

   typedef enum logic {IDLE, BEAT} state_t;

   state_t      state;
   state_t      state_next;
   logic [12:0] off_q;
   logic [7:0]  len_q;
   logic        write_q;
   logic        hit_q;
   logic [7:0]  beat;
   logic        msip;
   logic [63:0] mtimecmp;
   logic [63:0] mtime;
   logic [31:0] prescaler;
   logic [12:0] beat_idx;
   logic        last_beat;
   logic        tick;
   logic        do_write;
   logic [63:0] wmask;
   logic [63:0] rdata;
   logic        unused_bus;

   // Size and burst are ignored: every access is a full-word INCR beat.
   assign unused_bus = ^{bus.size, bus.burst, bus.addr[2:0]};

   assign beat_idx  = off_q + {5'd0, beat};
   assign last_beat = (beat == len_q);
   assign tick      = (prescaler == DIV_M1);
   assign do_write  = (state == BEAT) && write_q && hit_q;
   assign trint     = (mtime >= mtimecmp);
   assign swint     = msip;

   always_comb begin
      wmask = '0;
      for (int b = 0; b < 8; b++) begin
         wmask[b*8 +: 8] = {8{bus.strobe[b]}};
      end
   end

   always_comb begin
      rdata = '0;
      if (hit_q) begin
         case (beat_idx)
            MSIP_IDX:  rdata = {63'd0, msip};
            CMP_IDX:   rdata = mtimecmp;
            MTIME_IDX: rdata = mtime;
            default:   rdata = '0;
         endcase
      end
   end

   always_comb begin
      state_next    = state;
      bus.ready     = 1'b0;
      bus.last      = 1'b0;
      bus.resp_data = '0;
      case (state)
         IDLE: begin
            if (bus.valid) state_next = BEAT;
         end
         BEAT: begin
            bus.ready     = 1'b1;
            bus.last      = last_beat;
            bus.resp_data = rdata;
            if (last_beat) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         off_q   <= '0;
         len_q   <= '0;
         write_q <= 1'b0;
         hit_q   <= 1'b0;
         beat    <= '0;
      end else if (state == IDLE) begin
         if (bus.valid) begin
            off_q   <= bus.addr[15:3];
            len_q   <= bus.len;
            write_q <= bus.is_write;
            hit_q   <= (bus.addr[63:16] == BASE[63:16]);
            beat    <= '0;
         end
      end else if (!last_beat) begin
         beat <= beat + 8'd1;
      end
   end

   // A bus write to mtime is placed after the tick so the written value wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         msip      <= 1'b0;
         mtimecmp  <= '1;
         mtime     <= '0;
         prescaler <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 32'd1;
         if (tick) mtime <= mtime + 64'd1;
         if (do_write) begin
            case (beat_idx)
               MSIP_IDX:  if (bus.strobe[0]) msip <= bus.req_data[0];
               CMP_IDX:   mtimecmp <= (bus.req_data & wmask) | (mtimecmp & ~wmask);
               MTIME_IDX: mtime    <= (bus.req_data & wmask) | (mtime & ~wmask);
               default:   ;
            endcase
         end
      end
   end
endmodule
